// File: rtl/motor_pkg.sv
// Shared types and constants for the stepper motor controller: FSM states,
// the 4-phase full-step coil table and the angle-to-steps conversion.
package motor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam int NUM_MOTORS = 4;
    localparam int STEPS_W    = 12;
    localparam int ANGLE_W    = 9;

    localparam logic DIR_FORWARD  = 1'b1;
    localparam logic DIR_BACKWARD = 1'b0;

    localparam logic [2:0] MOTOR_1 = 3'd1;
    localparam logic [2:0] MOTOR_2 = 3'd2;
    localparam logic [2:0] MOTOR_3 = 3'd3;
    localparam logic [2:0] MOTOR_4 = 3'd4;

    // Full-step two-coils-on sequence; index order is the FORWARD rotation.
    function automatic logic [3:0] phase_pattern(input logic [1:0] idx);
        logic [3:0] pat;
        pat = 4'b0011;
        case (idx)
            2'd0: pat = 4'b0011;
            2'd1: pat = 4'b0110;
            2'd2: pat = 4'b1100;
            2'd3: pat = 4'b1001;
            default: pat = 4'b0011;
        endcase
        return pat;
    endfunction

    // step_num is steps-per-degree in Q8, so the product is shifted down by 8.
    function automatic logic [STEPS_W-1:0] angle_to_steps(input logic [ANGLE_W-1:0] angle,
                                                          input int step_num);
        logic [31:0] prod;
        prod = 32'(angle) * 32'(step_num);
        return STEPS_W'(prod >> 8);
    endfunction

endpackage

// File: rtl/motor_step_ctrl_step_tick_gen.sv
// Step-rate prescaler: counts 0..STEP_DIV-1 and pulses tick on the last count.
// Holding clear keeps the count at zero so the first step period is full length.
module step_tick_gen #(
    parameter int STEP_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);
    localparam int CNT_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;

    assign tick = !clear && (cnt_reg == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clear || tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/motor_step_ctrl.sv
// Executes one move command on one of four steppers: converts degrees to full
// steps and walks that motor's coil phase at the prescaled step rate.
module motor_step_ctrl
    import motor_pkg::*;
#(
    parameter int STEP_DIV  = 50000,
    parameter int STEP_NUM  = 1456,
    parameter int ANGLE_MAX = 360
) (
    input  logic         in_Clk,
    input  logic         in_Rst,
    input  logic         i_cmd_valid,
    input  logic [2:0]   i_motor_id,
    input  logic         i_dir,
    input  logic [8:0]   i_angle,
    output logic         o_cmd_ready,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_err,
    output logic [3:0]   out_Motor_PWM_A,
    output logic [3:0]   out_Motor_PWM_B,
    output logic [3:0]   out_Motor_PWM_C,
    output logic [3:0]   out_Motor_PWM_D
);

    state_t               state_reg;
    logic [1:0]           id_reg;
    logic                 dir_reg;
    logic [ANGLE_W-1:0]   angle_reg;
    logic [STEPS_W-1:0]   remaining_reg;
    logic [1:0]           phase_reg [NUM_MOTORS];
    logic [3:0]           pwm_reg   [NUM_MOTORS];
    logic                 ready_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic                 err_reg;

    logic [1:0]           sel;
    logic [1:0]           next_phase;
    logic [STEPS_W-1:0]   load_steps;
    logic [3:0]           pwm_step  [NUM_MOTORS];
    logic                 cmd_bad;
    logic                 tick;

    // Motor ids 1..4 map to slots 0..3 (id 4 wraps to 0 in two bits).
    assign sel        = id_reg - 2'd1;
    assign next_phase = (dir_reg == DIR_FORWARD) ? phase_reg[sel] + 2'd1
                                                 : phase_reg[sel] - 2'd1;
    assign load_steps = angle_to_steps(angle_reg, STEP_NUM);
    assign cmd_bad    = (i_motor_id < MOTOR_1) || (i_motor_id > MOTOR_4) ||
                        (int'(i_angle) > ANGLE_MAX);

    for (genvar gi = 0; gi < NUM_MOTORS; gi++) begin : g_step
        assign pwm_step[gi] = (sel == 2'(gi)) ? phase_pattern(next_phase) : 4'b0000;
    end

    step_tick_gen #(
        .STEP_DIV (STEP_DIV)
    ) u_tick (
        .clk   (in_Clk),
        .rst_n (in_Rst),
        .clear (state_reg != ST_RUN),
        .tick  (tick)
    );

    always_ff @(posedge in_Clk or negedge in_Rst) begin
        if (!in_Rst) begin
            state_reg     <= ST_IDLE;
            id_reg        <= 2'd0;
            dir_reg       <= DIR_BACKWARD;
            angle_reg     <= '0;
            remaining_reg <= '0;
            ready_reg     <= 1'b1;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            for (int i = 0; i < NUM_MOTORS; i++) begin
                phase_reg[i] <= 2'd0;
                pwm_reg[i]   <= 4'b0000;
            end
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (i_cmd_valid && ready_reg) begin
                        id_reg    <= i_motor_id[1:0];
                        dir_reg   <= i_dir;
                        angle_reg <= i_angle;
                        ready_reg <= 1'b0;
                        if (cmd_bad) begin
                            state_reg <= ST_ERR;
                            err_reg   <= 1'b1;
                        end else begin
                            state_reg <= ST_LOAD;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (load_steps == '0) begin
                        state_reg <= ST_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        // First step is taken on RUN entry, so one fewer remains.
                        state_reg      <= ST_RUN;
                        remaining_reg  <= load_steps - 1'b1;
                        phase_reg[sel] <= next_phase;
                        for (int i = 0; i < NUM_MOTORS; i++) pwm_reg[i] <= pwm_step[i];
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        if (remaining_reg == '0) begin
                            state_reg <= ST_DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            for (int i = 0; i < NUM_MOTORS; i++) pwm_reg[i] <= 4'b0000;
                        end else begin
                            remaining_reg  <= remaining_reg - 1'b1;
                            phase_reg[sel] <= next_phase;
                            for (int i = 0; i < NUM_MOTORS; i++) pwm_reg[i] <= pwm_step[i];
                        end
                    end
                end
                ST_DONE, ST_ERR: begin
                    state_reg <= ST_IDLE;
                    ready_reg <= 1'b1;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    ready_reg <= 1'b1;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign o_cmd_ready     = ready_reg;
    assign o_busy          = busy_reg;
    assign o_done          = done_reg;
    assign o_err           = err_reg;
    assign out_Motor_PWM_A = pwm_reg[0];
    assign out_Motor_PWM_B = pwm_reg[1];
    assign out_Motor_PWM_C = pwm_reg[2];
    assign out_Motor_PWM_D = pwm_reg[3];

endmodule

// File: doc/motor_step_ctrl.md
Name: motor_step_ctrl

Overview:
Downstream stage of the keypad/command state machine. It accepts one parsed move command (motor 1-4, direction, angle in degrees 0-360) and drives the 4-phase coil pattern of the selected stepper motor for the required number of full steps, at a programmable step rate. It reports busy, done and error status back to the command state machine. Each motor's phase position is retained between moves.

Parameters:
STEP_DIV, 50000, clock cycles each step pattern is held (minimum 2; use 4 in simulation)
STEP_NUM, 1456, steps-per-degree in Q8 fixed point (2048 steps/rev ÷ 360 × 256)
ANGLE_MAX, 360, largest legal angle in degrees

Ports:
in_Clk  input  1  system clock
in_Rst  input  1  reset, asynchronous, active-low
i_cmd_valid  input  1  command present; accepted when i_cmd_valid && o_cmd_ready
i_motor_id  input  3  target motor; 1..4 are legal
i_dir  input  1  1 = FORWARD, 0 = BACKWARD
i_angle  input  9  angle in degrees, binary
o_cmd_ready  output  1  block is IDLE and can accept a command
o_busy  output  1  move in progress (LOAD or RUN)
o_done  output  1  one-cycle pulse when a move completes
o_err  output  1  one-cycle pulse when a command is rejected
out_Motor_PWM_A  output  4  coil pattern, motor 1
out_Motor_PWM_B  output  4  coil pattern, motor 2
out_Motor_PWM_C  output  4  coil pattern, motor 3
out_Motor_PWM_D  output  4  coil pattern, motor 4

Behaviour:
- Reset values: all out_Motor_PWM_* = 4'b0000; o_busy, o_done and o_err = 0; o_cmd_ready = 1; all four phase indices = 0; FSM = IDLE.
- Phase LUT (index 0..3): 4'b0011, 4'b0110, 4'b1100, 4'b1001.
- FSM states: IDLE, LOAD, RUN, DONE, ERR.
- IDLE: o_cmd_ready = 1. On accept (cycle 0), latch id, dir and angle.
  - If id is not in 1..4, or angle > ANGLE_MAX: go to ERR.
  - Otherwise: go to LOAD.
- ERR: o_err = 1 for one cycle (cycle 1); no coil activity; then IDLE.
- LOAD (cycle 1): steps = (angle × STEP_NUM) >> 8, 12-bit result, truncating.
  - Examples: 128° gives 728 steps; 87° gives 494; 210° gives 1194; 7° gives 39; 360° gives 2047.
  - If steps == 0: go to DONE. Otherwise: go to RUN.
- RUN:
  - On entry and every STEP_DIV cycles after that, the selected motor's phase index is updated, +1 mod 4 for FORWARD or −1 mod 4 for BACKWARD.
  - The selected output drives LUT[new index], so the first pattern appears on cycle 2.
  - Each pattern is held for exactly STEP_DIV cycles.
  - After the Nth pattern has been held STEP_DIV cycles, go to DONE.
  - RUN therefore lasts N × STEP_DIV cycles.
- DONE: o_done = 1 for one cycle; then IDLE, and o_cmd_ready is high on the following cycle.
- Non-selected motors always output 4'b0000. All outputs are 4'b0000 outside RUN (coils de-energised while idle).
- o_busy = 1 in LOAD and RUN only.
- Commands presented while not in IDLE are ignored (o_cmd_ready = 0) and are not queued.
- The phase index persists per motor across moves. It is cleared only by reset.
- Reset asserted mid-move: immediate abort, all outputs return to reset values, no o_done pulse.
- Step prescaler: a counter from 0 to STEP_DIV−1, cleared on RUN entry. A wrap-around marks a step boundary.

Decomposition:
- Shared package motor_pkg holds:
  - state enum typedef;
  - phase LUT constant;
  - DIR_FORWARD / DIR_BACKWARD constants;
  - motor id constants MOTOR_1..MOTOR_4;
  - steps width localparam.
- One sub-module, step_tick_gen: the STEP_DIV prescaler with a clear input, producing a one-cycle tick.

Test Plan:
- Reset, then motor 2, FORWARD, 128° (STEP_DIV=4):
  - o_busy rises on cycle 1.
  - out_Motor_PWM_B = 0110 on cycle 2.
  - 728 patterns, 2912 cycles in total; last pattern 0011.
  - o_done pulses once.
  - Outputs A, C and D stay 0000 throughout.
- Next, motor 1, BACKWARD, 87°:
  - first pattern 1001;
  - 494 steps;
  - last pattern 1100;
  - then o_done.
- Motor 2, FORWARD, 7° after test 1: first pattern 0110 (index continues from 0); final index 3, giving 1001.
- Angle 0: o_done on cycle 2, no coil activity. Angle 400 or motor id 5: o_err on cycle 1, no o_done, no coil activity.
- A second i_cmd_valid during RUN is ignored; the step count of the active move is unchanged.
- in_Rst pulled low mid-RUN: all outputs 0000 at once and o_cmd_ready = 1; the next move starts at LUT[1].
